updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
- Scheduler for the 4-bit up/down counter datapath.
- Accepts a sweep command (low bound, high bound, sweep count) over a valid/ready handshake.
- Owns and sequences the counter so it ping-pongs lo→hi→lo the requested number of times.
- Supports pause and abort, and reports done and error pulses.
- Sits between a host or test sequencer and any logic consuming the count value.

Parameters:
- WIDTH, 4, counter/bound width.
- SW_W, 4, width of sweep-count field and sweep counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_lo  in  WIDTH  lower bound.
- cmd_hi  in  WIDTH  upper bound.
- cmd_sweeps  in  SW_W  number of full lo→hi→lo sweeps.
- pause  in  1  level; freeze counting while high.
- abort  in  1  level; cancel the active sweep.
- count  out  WIDTH  counter value.
- up_down  out  1  1 = counting up, 0 = down or idle.
- busy  out  1  sweep in progress.
- sweep_cnt  out  SW_W  completed sweeps of the current command.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; count=0, up_down=0, busy=0, sweep_cnt=0, done=0, err=0.
  - cmd_ready=1 once reset deasserts.
- States: IDLE, UP, DOWN, FIN.
- Combinational outputs: cmd_ready = (state==IDLE); busy = (state==UP or DOWN); up_down = (state==UP).
- IDLE:
  - Accept on cmd_valid && cmd_ready.
  - If cmd_lo >= cmd_hi or cmd_sweeps==0: err=1 for one cycle, stay IDLE, count unchanged.
  - Else latch hi/sweeps, count<=cmd_lo, sweep_cnt<=0, go to UP.
- UP, not paused:
  - count<hi: count<=count+1.
  - count==hi: count<=hi-1, go to DOWN.
- DOWN, not paused:
  - count>lo: count<=count-1.
  - count==lo: the sweep is complete; sweep_cnt<=sweep_cnt+1.
    - If sweep_cnt+1==sweeps: go to FIN, count holds lo.
    - Else count<=lo+1, go to UP.
- FIN: done=1 for exactly one cycle, then IDLE. count holds lo; sweep_cnt holds its final value until the next accept.
- Sweep timing: one sweep = 2*(hi-lo) cycles from leaving lo to the return to lo. First increment occurs on the edge after accept.
- pause (UP/DOWN only): count, state and sweep_cnt are frozen. No effect in IDLE/FIN.
- abort (UP/DOWN):
  - Next edge → IDLE; count holds its current value; no done.
  - abort has priority over pause and over a same-cycle bound turnaround.
- abort in IDLE or FIN: ignored; FIN still pulses done.
- cmd_valid while not IDLE: ignored, not queued.
- No wrap-around: the bound check guarantees lo < hi. hi=2^WIDTH-1 is legal and count reaches all-ones without overflow.
- Arithmetic: sweep_cnt compare uses the SW_W+1-bit sum, so sweeps=2^SW_W-1 works.
- Reset mid-sweep: immediate return to the reset values above.

Decomposition:
- Package updown_sweep_pkg:
  - state enum (IDLE, UP, DOWN, FIN);
  - default WIDTH/SW_W constants;
  - command struct {lo, hi, sweeps}.
- One natural sub-module, sweep_step_counter:
  - a WIDTH-bit loadable up/down register with load, en, up_down, asynchronous active-high reset;
  - the FSM drives its load/en/dir.

Test Plan:
- reset=1 for 2 cycles, release → count=0, cmd_ready=1, busy=0, done=0, err=0.
- cmd lo=2 hi=5 sweeps=1 → count 2,3,4,5,4,3,2; up_down=1 through 5; sweep_cnt=1; done pulses once; cmd_ready returns.
- cmd lo=0 hi=15 sweeps=2 → count reaches 15 without wrap; two 30-cycle sweeps; sweep_cnt=2; single done.
- cmd lo=7 hi=7 or sweeps=0 → err one cycle, state stays IDLE, count unchanged.
- lo=1 hi=6 sweeps=3; pause 4 cycles at count=4 going up → count holds 4 for 4 cycles, total duration +4 cycles. Then abort at count=3 with pause also high → IDLE next edge, count=3, no done.
- Assert reset mid-DOWN (count=5) → count=0 asynchronously; cmd_valid during UP is ignored (cmd_ready=0).

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg: shared states, default widths and command layout for the sweep controller
package updown_sweep_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SW_W = 4;
  typedef enum logic [1:0] {IDLE, UP, DOWN, FIN} state_t;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] lo;
    logic [DEF_WIDTH-1:0] hi;
    logic [DEF_SW_W-1:0] sweeps;
  } cmd_t;
endpackage

// File: rtl/updown_sweep_ctrl_counter.sv
// sweep_step_counter: loadable up/down register stepped by the sweep FSM
module sweep_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: accepts sweep commands and ping-pongs the counter lo->hi->lo the requested times
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW_W = DEF_SW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [SW_W-1:0]  cmd_sweeps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             busy,
  output logic [SW_W-1:0]  sweep_cnt,
  output logic             done,
  output logic             err
);
  state_t state, next;
  logic [WIDTH-1:0] lo_r, hi_r, ld_val;
  logic [SW_W-1:0] sweeps_r;
  logic [SW_W:0] sw_sum;
  logic ld, en, dir, accept, reject, sw_inc;
  assign cmd_ready = state == IDLE;
  assign busy = state == UP || state == DOWN;
  assign up_down = state == UP;
  assign done = state == FIN;
  // one bit wider so a maximal sweep count still compares correctly
  assign sw_sum = {1'b0, sweep_cnt} + (SW_W+1)'(1);
  sweep_step_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .reset(reset), .load(ld), .en(en), .up_down(dir), .load_val(ld_val), .count(count)
  );
  always_comb begin
    next = state;
    ld = 1'b0;
    en = 1'b0;
    dir = 1'b0;
    ld_val = cmd_lo;
    accept = 1'b0;
    reject = 1'b0;
    sw_inc = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        if (cmd_lo >= cmd_hi || cmd_sweeps == '0) reject = 1'b1;
        else begin
          accept = 1'b1;
          ld = 1'b1;
          next = UP;
        end
      end
      UP: if (abort) next = IDLE;
      else if (!pause) begin
        en = 1'b1;
        dir = count < hi_r;
        if (count == hi_r) next = DOWN;
      end
      DOWN: if (abort) next = IDLE;
      else if (!pause) begin
        if (count > lo_r) en = 1'b1;
        else begin
          sw_inc = 1'b1;
          if (sw_sum == {1'b0, sweeps_r}) next = FIN;
          else begin
            ld = 1'b1;
            ld_val = lo_r + WIDTH'(1);
            next = UP;
          end
        end
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lo_r <= '0;
      hi_r <= '0;
      sweeps_r <= '0;
      sweep_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= next;
      err <= reject;
      if (accept) begin
        lo_r <= cmd_lo;
        hi_r <= cmd_hi;
        sweeps_r <= cmd_sweeps;
        sweep_cnt <= '0;
      end else if (sw_inc) sweep_cnt <= sw_sum[SW_W-1:0];
    end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed checks of sweep sequencing, rejects, pause/abort and async reset
module tb_updown_sweep_ctrl;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [3:0] cmd_lo = '0, cmd_hi = '0, cmd_sweeps = '0;
  logic cmd_ready, up_down, busy, done, err;
  logic [3:0] count, sweep_cnt;
  int n_run = 0, n_fail = 0;
  updown_sweep_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_sweeps(cmd_sweeps), .pause(pause), .abort(abort),
    .count(count), .up_down(up_down), .busy(busy), .sweep_cnt(sweep_cnt), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] sw);
    cmd_valid = 1'b1;
    cmd_lo = lo;
    cmd_hi = hi;
    cmd_sweeps = sw;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int exp_cnt[7] = '{2, 3, 4, 5, 4, 3, 2};
    int exp_ud[7] = '{1, 1, 1, 1, 0, 0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sweep_cnt", sweep_cnt, 0);
    send(2, 5, 1);
    for (int i = 0; i < 7; i++) begin
      chk("s1_count", count, exp_cnt[i]);
      chk("s1_up_down", up_down, exp_ud[i]);
      chk("s1_busy", busy, 1);
      chk("s1_done_low", done, 0);
      @(negedge clk);
    end
    chk("s1_done", done, 1);
    chk("s1_sweep_cnt", sweep_cnt, 1);
    chk("s1_fin_count", count, 2);
    chk("s1_fin_busy", busy, 0);
    @(negedge clk);
    chk("s1_done_once", done, 0);
    chk("s1_ready_back", cmd_ready, 1);
    chk("s1_sweep_hold", sweep_cnt, 1);
    send(7, 7, 3);
    chk("rej_eq_err", err, 1);
    chk("rej_eq_ready", cmd_ready, 1);
    chk("rej_eq_busy", busy, 0);
    chk("rej_eq_count", count, 2);
    @(negedge clk);
    chk("rej_eq_err_pulse", err, 0);
    send(3, 9, 0);
    chk("rej_sw0_err", err, 1);
    chk("rej_sw0_count", count, 2);
    send(9, 3, 1);
    chk("rej_inv_err", err, 1);
    chk("rej_inv_busy", busy, 0);
    @(negedge clk);
    chk("rej_inv_err_pulse", err, 0);
    send(0, 15, 2);
    for (int k = 0; k <= 60; k++) begin
      int m;
      m = k % 30;
      chk("s2_count", count, m <= 15 ? m : 30 - m);
      chk("s2_up_down", up_down, (k == 0 || (m >= 1 && m <= 15)) ? 1 : 0);
      chk("s2_sweep_cnt", sweep_cnt, k <= 30 ? 0 : 1);
      chk("s2_done_low", done, 0);
      @(negedge clk);
    end
    chk("s2_done", done, 1);
    chk("s2_sweep_final", sweep_cnt, 2);
    chk("s2_fin_count", count, 0);
    @(negedge clk);
    chk("s2_done_once", done, 0);
    chk("s2_idle_ready", cmd_ready, 1);
    send(1, 6, 3);
    chk("s3_count0", count, 1);
    repeat (3) @(negedge clk);
    chk("s3_count_pre_pause", count, 4);
    pause = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("s3_pause_count", count, 4);
      chk("s3_pause_busy", busy, 1);
      chk("s3_pause_up", up_down, 1);
    end
    pause = 1'b0;
    @(negedge clk);
    chk("s3_resume5", count, 5);
    @(negedge clk);
    chk("s3_hi6", count, 6);
    @(negedge clk);
    chk("s3_down5", count, 5);
    chk("s3_down_dir", up_down, 0);
    @(negedge clk);
    @(negedge clk);
    chk("s3_down3", count, 3);
    abort = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pause = 1'b0;
    chk("s3_abort_count", count, 3);
    chk("s3_abort_ready", cmd_ready, 1);
    chk("s3_abort_busy", busy, 0);
    chk("s3_abort_done", done, 0);
    @(negedge clk);
    chk("s3_abort_no_done", done, 0);
    chk("s3_abort_hold", count, 3);
    send(2, 7, 1);
    @(negedge clk);
    chk("s4_up3", count, 3);
    chk("s4_ready_busy", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_lo = 0;
    cmd_hi = 1;
    cmd_sweeps = 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("s4_cmd_ignored", count, 4);
    chk("s4_still_up", up_down, 1);
    repeat (5) @(negedge clk);
    chk("s4_mid_down", count, 5);
    chk("s4_mid_dir", up_down, 0);
    #2 reset = 1'b1;
    #1;
    chk("s4_async_count", count, 0);
    chk("s4_async_busy", busy, 0);
    chk("s4_async_ready", cmd_ready, 1);
    chk("s4_async_sweep", sweep_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("s4_post_count", count, 0);
    chk("s4_post_done", done, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
